// File: rtl/wb_stage_if.sv
// Write-back stage bundle: retiring-instruction input, trap vector, and all write-back outputs.
// master is the stage itself; slave is the memory stage / commit block side.
interface wb_stage_if #(
  parameter int unsigned XLEN = 64
);
  logic            io_in_valid;
  logic            io_in_ready;
  logic [XLEN-1:0] io_in_pc;
  logic [XLEN-1:0] io_in_next_pc;
  logic [31:0]     io_in_inst;
  logic            io_in_rd_en;
  logic [4:0]      io_in_rd_addr;
  logic [XLEN-1:0] io_in_rd_data;
  logic            io_in_csr_en;
  logic [11:0]     io_in_csr_addr;
  logic [XLEN-1:0] io_in_csr_data;
  logic            io_in_is_except;
  logic [5:0]      io_in_exception;
  logic            io_in_time_irq;
  logic            io_in_soft_irq;
  logic            io_in_peripheral;
  logic [XLEN-1:0] io_csr_mtvec;

  logic            io_normal_wb_valid;
  logic [4:0]      io_normal_wb_dest_addr;
  logic [XLEN-1:0] io_normal_wb_dest_data;
  logic            io_csr_wb_valid;
  logic [11:0]     io_csr_wb_csr_addr;
  logic [XLEN-1:0] io_csr_wb_csr_data;
  logic            io_csr_except_is_except;
  logic            io_csr_except_is_time_irq;
  logic            io_csr_except_is_soft_irq;
  logic [5:0]      io_csr_except_exception;
  logic [XLEN-1:0] io_csr_except_pc;
  logic [XLEN-1:0] io_csr_except_next_pc;
  logic            io_commit;
  logic [31:0]     io_difftest_inst;
  logic            io_difftest_peripheral;
  logic            io_flush;
  logic [XLEN-1:0] io_flush_pc;

  modport master (
    input  io_in_valid, io_in_pc, io_in_next_pc, io_in_inst, io_in_rd_en, io_in_rd_addr,
           io_in_rd_data, io_in_csr_en, io_in_csr_addr, io_in_csr_data, io_in_is_except,
           io_in_exception, io_in_time_irq, io_in_soft_irq, io_in_peripheral, io_csr_mtvec,
    output io_in_ready, io_normal_wb_valid, io_normal_wb_dest_addr, io_normal_wb_dest_data,
           io_csr_wb_valid, io_csr_wb_csr_addr, io_csr_wb_csr_data, io_csr_except_is_except,
           io_csr_except_is_time_irq, io_csr_except_is_soft_irq, io_csr_except_exception,
           io_csr_except_pc, io_csr_except_next_pc, io_commit, io_difftest_inst,
           io_difftest_peripheral, io_flush, io_flush_pc
  );

  modport slave (
    output io_in_valid, io_in_pc, io_in_next_pc, io_in_inst, io_in_rd_en, io_in_rd_addr,
           io_in_rd_data, io_in_csr_en, io_in_csr_addr, io_in_csr_data, io_in_is_except,
           io_in_exception, io_in_time_irq, io_in_soft_irq, io_in_peripheral, io_csr_mtvec,
    input  io_in_ready, io_normal_wb_valid, io_normal_wb_dest_addr, io_normal_wb_dest_data,
           io_csr_wb_valid, io_csr_wb_csr_addr, io_csr_wb_csr_data, io_csr_except_is_except,
           io_csr_except_is_time_irq, io_csr_except_is_soft_irq, io_csr_except_exception,
           io_csr_except_pc, io_csr_except_next_pc, io_commit, io_difftest_inst,
           io_difftest_peripheral, io_flush, io_flush_pc
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: registers one retiring instruction per cycle, drives GPR/CSR/trap/commit
// outputs one cycle later, and flushes plus drains the input for FLUSH_CYCLES after a trap.
module wb_stage #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned XLEN         = 64
) (
  input  logic       clock,
  input  logic       reset,
  wb_stage_if.master wb
);
  localparam int unsigned CntW = $clog2(FLUSH_CYCLES) + 1;

  typedef enum logic [1:0] {StRun, StFlush, StDrain} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ready, xfer, trap;

  logic            nwb_valid_q, cwb_valid_q, commit_q;
  logic            is_except_q, time_irq_q, soft_irq_q;
  logic [4:0]      dest_addr_q;
  logic [XLEN-1:0] dest_data_q, csr_data_q, pc_q, next_pc_q;
  logic [11:0]     csr_addr_q;
  logic [5:0]      exception_q;
  logic [31:0]     inst_q;
  logic            periph_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = (state_q == StRun);
    trap    = wb.io_in_is_except | wb.io_in_time_irq | wb.io_in_soft_irq;
    xfer    = wb.io_in_valid & ready;
    unique case (state_q)
      StRun: begin
        if (xfer && trap) begin
          state_d = StFlush;
          cnt_d   = CntW'(FLUSH_CYCLES - 1);
        end
      end
      StFlush: state_d = (cnt_q == '0) ? StRun : StDrain;
      StDrain: begin
        // Counter holds the remaining drain cycles including this one.
        if (cnt_q <= CntW'(1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      nwb_valid_q <= 1'b0;
      cwb_valid_q <= 1'b0;
      commit_q    <= 1'b0;
      is_except_q <= 1'b0;
      time_irq_q  <= 1'b0;
      soft_irq_q  <= 1'b0;
      dest_addr_q <= '0;
      dest_data_q <= '0;
      csr_addr_q  <= '0;
      csr_data_q  <= '0;
      exception_q <= '0;
      pc_q        <= '0;
      next_pc_q   <= '0;
      inst_q      <= '0;
      periph_q    <= 1'b0;
    end else begin
      commit_q    <= xfer;
      nwb_valid_q <= xfer & wb.io_in_rd_en & (wb.io_in_rd_addr != 5'd0) & ~trap;
      cwb_valid_q <= xfer & wb.io_in_csr_en & ~trap;
      is_except_q <= xfer & wb.io_in_is_except;
      time_irq_q  <= xfer & wb.io_in_time_irq;
      soft_irq_q  <= xfer & wb.io_in_soft_irq;
      // Payload fields hold their last value on idle cycles.
      if (xfer) begin
        dest_addr_q <= wb.io_in_rd_addr;
        dest_data_q <= wb.io_in_rd_data;
        csr_addr_q  <= wb.io_in_csr_addr;
        csr_data_q  <= wb.io_in_csr_data;
        exception_q <= wb.io_in_exception;
        pc_q        <= wb.io_in_pc;
        next_pc_q   <= wb.io_in_next_pc;
        inst_q      <= wb.io_in_inst;
        periph_q    <= wb.io_in_peripheral;
      end
    end
  end

  assign wb.io_in_ready               = ready;
  assign wb.io_normal_wb_valid        = nwb_valid_q;
  assign wb.io_normal_wb_dest_addr    = dest_addr_q;
  assign wb.io_normal_wb_dest_data    = dest_data_q;
  assign wb.io_csr_wb_valid           = cwb_valid_q;
  assign wb.io_csr_wb_csr_addr        = csr_addr_q;
  assign wb.io_csr_wb_csr_data        = csr_data_q;
  assign wb.io_csr_except_is_except   = is_except_q;
  assign wb.io_csr_except_is_time_irq = time_irq_q;
  assign wb.io_csr_except_is_soft_irq = soft_irq_q;
  assign wb.io_csr_except_exception   = exception_q;
  assign wb.io_csr_except_pc          = pc_q;
  assign wb.io_csr_except_next_pc     = next_pc_q;
  assign wb.io_commit                 = commit_q;
  assign wb.io_difftest_inst          = inst_q;
  assign wb.io_difftest_peripheral    = periph_q;
  assign wb.io_flush                  = (state_q == StFlush);
  // Redirect target is the trap vector as presented during the flush cycle.
  assign wb.io_flush_pc               = (state_q == StFlush) ? wb.io_csr_mtvec : '0;
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_wb_stage;
  localparam int unsigned FC   = 2;
  localparam int unsigned XLEN = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  wb_stage_if #(.XLEN(XLEN)) bus ();

  wb_stage #(.FLUSH_CYCLES(FC), .XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (bus.master)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: blk counts cycles the input is still refused.
  int          m_blk = 0;
  bit          m_live = 0;
  bit          m_acc, m_trap;
  bit          e_commit, e_nv, e_cv, e_ex, e_ti, e_si, e_flush, e_periph;
  logic [4:0]  e_rd;
  logic [11:0] e_caddr;
  logic [5:0]  e_cause;
  logic [31:0] e_inst;
  logic [63:0] e_rdata, e_cdata, e_pc, e_npc;

  always @(posedge clock) begin
    if (reset) begin
      m_live = 1; m_blk = 0;
      e_commit = 0; e_nv = 0; e_cv = 0; e_ex = 0; e_ti = 0; e_si = 0; e_flush = 0;
      e_periph = 0; e_rd = 0; e_caddr = 0; e_cause = 0; e_inst = 0;
      e_rdata = 0; e_cdata = 0; e_pc = 0; e_npc = 0;
    end else if (m_live) begin
      m_acc  = bus.io_in_valid && (m_blk == 0);
      m_trap = bus.io_in_is_except || bus.io_in_time_irq || bus.io_in_soft_irq;
      if (m_blk > 0) m_blk--;
      e_commit = m_acc;
      e_nv     = m_acc && bus.io_in_rd_en && (bus.io_in_rd_addr != 0) && !m_trap;
      e_cv     = m_acc && bus.io_in_csr_en && !m_trap;
      e_ex     = m_acc && bus.io_in_is_except;
      e_ti     = m_acc && bus.io_in_time_irq;
      e_si     = m_acc && bus.io_in_soft_irq;
      e_flush  = m_acc && m_trap;
      if (m_acc) begin
        e_rd = bus.io_in_rd_addr;   e_rdata = bus.io_in_rd_data;
        e_caddr = bus.io_in_csr_addr; e_cdata = bus.io_in_csr_data;
        e_cause = bus.io_in_exception; e_pc = bus.io_in_pc; e_npc = bus.io_in_next_pc;
        e_inst = bus.io_in_inst; e_periph = bus.io_in_peripheral;
        if (m_trap) m_blk = FC;
      end
    end
  end

  always @(negedge clock) begin
    if (m_live) begin
      chk("ready", bus.io_in_ready, m_blk == 0);
      chk("commit", bus.io_commit, e_commit);
      chk("flush", bus.io_flush, e_flush);
      if (e_flush) chk("flush_pc", bus.io_flush_pc, bus.io_csr_mtvec);
      chk("nwb_valid", bus.io_normal_wb_valid, e_nv);
      chk("cwb_valid", bus.io_csr_wb_valid, e_cv);
      chk("is_except", bus.io_csr_except_is_except, e_ex);
      chk("time_irq", bus.io_csr_except_is_time_irq, e_ti);
      chk("soft_irq", bus.io_csr_except_is_soft_irq, e_si);
      chk("dest_addr", bus.io_normal_wb_dest_addr, e_rd);
      chk("dest_data", bus.io_normal_wb_dest_data, e_rdata);
      chk("csr_addr", bus.io_csr_wb_csr_addr, e_caddr);
      chk("csr_data", bus.io_csr_wb_csr_data, e_cdata);
      chk("cause", bus.io_csr_except_exception, e_cause);
      chk("pc", bus.io_csr_except_pc, e_pc);
      chk("next_pc", bus.io_csr_except_next_pc, e_npc);
      chk("diff_inst", bus.io_difftest_inst, e_inst);
      chk("diff_periph", bus.io_difftest_peripheral, e_periph);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.io_in_valid = 0; bus.io_in_pc = 0; bus.io_in_next_pc = 0; bus.io_in_inst = 0;
    bus.io_in_rd_en = 0; bus.io_in_rd_addr = 0; bus.io_in_rd_data = 0;
    bus.io_in_csr_en = 0; bus.io_in_csr_addr = 0; bus.io_in_csr_data = 0;
    bus.io_in_is_except = 0; bus.io_in_exception = 0; bus.io_in_time_irq = 0;
    bus.io_in_soft_irq = 0; bus.io_in_peripheral = 0;
  endtask

  initial begin
    idle();
    bus.io_csr_mtvec = 0;
    tick(); tick();
    reset = 0;
    chk("rst_ready", bus.io_in_ready, 1);
    chk("rst_commit", bus.io_commit, 0);
    chk("rst_flush_pc", bus.io_flush_pc, 0);
    chk("rst_pc", bus.io_csr_except_pc, 0);

    // 1: plain GPR write
    bus.io_in_valid = 1; bus.io_in_pc = 64'h8000_0000; bus.io_in_rd_en = 1;
    bus.io_in_rd_addr = 5; bus.io_in_rd_data = 64'h1234;
    tick(); idle();
    chk("t1_nv", bus.io_normal_wb_valid, 1);
    chk("t1_dest", bus.io_normal_wb_dest_addr, 5);
    chk("t1_data", bus.io_normal_wb_dest_data, 64'h1234);
    chk("t1_commit", bus.io_commit, 1);
    chk("t1_pc", bus.io_csr_except_pc, 64'h8000_0000);
    tick();
    chk("t1_idle_commit", bus.io_commit, 0);
    chk("t1_idle_nv", bus.io_normal_wb_valid, 0);

    // 2: write to x0
    bus.io_in_valid = 1; bus.io_in_rd_en = 1; bus.io_in_rd_addr = 0; bus.io_in_rd_data = 64'hFF;
    tick(); idle();
    chk("t2_commit", bus.io_commit, 1);
    chk("t2_nv", bus.io_normal_wb_valid, 0);

    // 3: CSR write
    bus.io_in_valid = 1; bus.io_in_csr_en = 1; bus.io_in_csr_addr = 12'h305;
    bus.io_in_csr_data = 64'h8000_1000;
    tick(); idle();
    chk("t3_cv", bus.io_csr_wb_valid, 1);
    chk("t3_caddr", bus.io_csr_wb_csr_addr, 12'h305);
    chk("t3_cdata", bus.io_csr_wb_csr_data, 64'h8000_1000);
    chk("t3_commit", bus.io_commit, 1);

    // 4: exception, flush and drain with input held valid
    bus.io_csr_mtvec = 64'h8000_2000;
    bus.io_in_valid = 1; bus.io_in_is_except = 1; bus.io_in_exception = 2;
    bus.io_in_rd_en = 1; bus.io_in_rd_addr = 3; bus.io_in_csr_en = 1;
    tick(); idle();
    bus.io_in_valid = 1; bus.io_in_rd_en = 1; bus.io_in_rd_addr = 7;
    chk("t4_commit", bus.io_commit, 1);
    chk("t4_is_except", bus.io_csr_except_is_except, 1);
    chk("t4_cause", bus.io_csr_except_exception, 2);
    chk("t4_nv", bus.io_normal_wb_valid, 0);
    chk("t4_cv", bus.io_csr_wb_valid, 0);
    chk("t4_flush", bus.io_flush, 1);
    chk("t4_flush_pc", bus.io_flush_pc, 64'h8000_2000);
    chk("t4_ready_f", bus.io_in_ready, 0);
    tick();
    chk("t4_ready_d", bus.io_in_ready, 0);
    chk("t4_drain_commit", bus.io_commit, 0);
    chk("t4_drain_flush", bus.io_flush, 0);
    tick(); idle();
    chk("t4_ready_r", bus.io_in_ready, 1);
    chk("t4_ignored", bus.io_commit, 0);

    // 5: back-to-back stream
    for (int i = 1; i <= 4; i++) begin
      bus.io_in_valid = 1; bus.io_in_rd_en = 1; bus.io_in_rd_addr = 5'(i);
      bus.io_in_rd_data = 64'(i * 16);
      tick();
      chk("t5_commit", bus.io_commit, 1);
      chk("t5_dest", bus.io_normal_wb_dest_addr, 5'(i));
    end
    idle();

    // 6: timer interrupt, reset during drain
    bus.io_in_valid = 1; bus.io_in_time_irq = 1; bus.io_in_pc = 64'h8000_0040;
    tick(); idle();
    chk("t6_tirq", bus.io_csr_except_is_time_irq, 1);
    chk("t6_ex0", bus.io_csr_except_is_except, 0);
    chk("t6_flush", bus.io_flush, 1);
    tick();
    chk("t6_drain", bus.io_in_ready, 0);
    reset = 1;
    tick();
    reset = 0;
    chk("t6_ready", bus.io_in_ready, 1);
    chk("t6_flush0", bus.io_flush, 0);
    chk("t6_commit0", bus.io_commit, 0);
    chk("t6_pc0", bus.io_csr_except_pc, 0);
    chk("t6_tirq0", bus.io_csr_except_is_time_irq, 0);
    bus.io_in_valid = 1; bus.io_in_rd_en = 1; bus.io_in_rd_addr = 9; bus.io_in_rd_data = 64'h55;
    tick(); idle();
    chk("t6_after_commit", bus.io_commit, 1);
    chk("t6_after_dest", bus.io_normal_wb_dest_addr, 9);

    // Randomized traffic; the every-cycle compare does the checking.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      bus.io_in_valid      = ($urandom_range(0, 9) < 7);
      bus.io_in_pc         = {$urandom, $urandom};
      bus.io_in_next_pc    = {$urandom, $urandom};
      bus.io_in_inst       = $urandom;
      bus.io_in_rd_en      = $urandom_range(0, 1) == 1;
      bus.io_in_rd_addr    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      bus.io_in_rd_data    = {$urandom, $urandom};
      bus.io_in_csr_en     = $urandom_range(0, 1) == 1;
      bus.io_in_csr_addr   = 12'($urandom);
      bus.io_in_csr_data   = {$urandom, $urandom};
      bus.io_in_is_except  = ($urandom_range(0, 9) == 0);
      bus.io_in_exception  = 6'($urandom);
      bus.io_in_time_irq   = ($urandom_range(0, 14) == 0);
      bus.io_in_soft_irq   = ($urandom_range(0, 14) == 0);
      bus.io_in_peripheral = $urandom_range(0, 1) == 1;
      bus.io_csr_mtvec     = {$urandom, $urandom};
      tick();
    end
    reset = 0;
    idle();
    tick(); tick(); tick();
    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
